// File: rtl/fpalu_pkg.sv
// Shared types for the FP32 adder scheduler: operand word and response FIFO entry.
package fpalu_pkg;
  localparam int FP32_W   = 32;
  localparam int ID_MAX_W = 3;  // wide enough for up to 8 requesters

  typedef logic [FP32_W-1:0] fp32_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    fp32_t               sum;
  } rsp_entry_t;
endpackage

// File: rtl/fpalu_add_sched_if.sv
// Bus bundle for the shared-adder scheduler: requester side, adder side, response side.
interface fpalu_add_sched_if
  import fpalu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  fp32_t [NUM_REQ-1:0]       req_a;
  fp32_t [NUM_REQ-1:0]       req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      add_valid;
  fp32_t                     add_a;
  fp32_t                     add_b;
  fp32_t                     add_sum;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  fp32_t                     rsp_sum;
  logic                      rsp_ready;

  // slave: the scheduler itself; master: requesters, adder and consumer around it
  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_valid, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );
  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_valid, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/fpalu_rsp_fifo.sv
// Generic first-word-fall-through FIFO; push and pop may coincide, even when full.
module fpalu_rsp_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so the response port idles at zero after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && full && !pop));
endmodule

// File: rtl/fpalu_add_sched.sv
// Round-robin scheduler sharing one fixed-latency FP32 adder; credits keep the
// non-stallable adder from overrunning the in-order response FIFO.
module fpalu_add_sched
  import fpalu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 3,
  parameter int RSP_DEPTH   = 4,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic              clock,
  input  logic              reset_n,
  fpalu_add_sched_if.slave  bus
);
  localparam int STAGES = ADD_LATENCY - 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;

  logic [ID_W-1:0]             ptr, win, win_hi, win_lo, ptr_nxt;
  logic [NUM_REQ-1:0]          hi_req;
  logic                        found, found_hi, credit_ok, issue, retire, pop;
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][ID_W-1:0]   id_pipe;
  logic [CNT_W-1:0]            inflight, fifo_count;
  logic [CNT_W:0]              used;
  logic                        fifo_empty, fifo_full;
  rsp_entry_t                  push_ent, head;

  // Credit uses registered counts only: a pop this cycle frees a slot next cycle.
  assign used      = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok = used < (CNT_W+1)'(RSP_DEPTH);

  // Requesters at or above ptr get first pick; otherwise wrap to the lowest index.
  assign hi_req = bus.req_valid & ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));

  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (hi_req[i]) begin
        found_hi = 1'b1;
        win_hi   = ID_W'(i);
      end
      if (bus.req_valid[i]) win_lo = ID_W'(i);
    end
  end

  assign found   = |bus.req_valid;
  assign win     = found_hi ? win_hi : win_lo;
  assign issue   = found & credit_ok & reset_n;
  assign ptr_nxt = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);

  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[win] = 1'b1;
  end

  assign retire = vld_pipe[STAGES];

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr           <= '0;
      bus.add_valid <= 1'b0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      vld_pipe      <= '0;
      id_pipe       <= '0;
      inflight      <= '0;
    end else begin
      bus.add_valid <= issue;
      // Tag stage 0 loads on the same edge as add_valid, so the tail lines up with add_sum.
      vld_pipe[0]   <= issue;
      id_pipe[0]    <= win;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
      if (issue) begin
        ptr       <= ptr_nxt;
        bus.add_a <= bus.req_a[win];
        bus.add_b <= bus.req_b[win];
      end
      unique case ({issue, retire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end

  assign push_ent.id  = ID_MAX_W'(id_pipe[STAGES]);
  assign push_ent.sum = bus.add_sum;
  assign pop          = ~fifo_empty & bus.rsp_ready;

  fpalu_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (retire),
    .din     (push_ent),
    .pop     (pop),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_id    = head.id[ID_W-1:0];
  assign bus.rsp_sum   = head.sum;

  grant_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(bus.req_ready));
  credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
    used <= (CNT_W+1)'(RSP_DEPTH));
endmodule

// File: tb/tb_fpalu_add_sched.sv
// Directed bench for fpalu_add_sched: acts as the 3-cycle adder and scoreboards every response.
module tb_fpalu_add_sched;
  import fpalu_pkg::*;

  localparam int NR = 4;
  localparam int L  = 3;
  localparam int D  = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fpalu_add_sched_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

  fpalu_add_sched #(
    .NUM_REQ(NR), .ADD_LATENCY(L), .RSP_DEPTH(D), .ID_W(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [1:0] id; fp32_t sum; } exp_t;
  exp_t sb[$];

  // fp32 <-> real through the double encoding, round-to-nearest-even back to fp32
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [31:0] res;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e   = d[62:52] - 11'd896;
    res = {d[63], e[7:0], d[51:29]};
    if (d[28] && (d[27:0] != 28'd0 || d[29])) res = res + 32'd1;
    return res;
  endfunction

  function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
    return to_fp32(to_real(a) + to_real(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Adder model: sum of the pair seen with add_valid appears two cycles later.
  fp32_t sp0 = '0, sp1 = '0;
  always @(posedge clock) begin
    sp1 <= sp0;
    sp0 <= fpadd(bus.add_a, bus.add_b);
  end
  assign bus.add_sum = sp1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Handshakes fill the scoreboard; accepted responses are matched in order.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("ready_onehot0", ($countones(bus.req_ready) <= 1), 1);
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{id: 2'(i), sum: fpadd(bus.req_a[i], bus.req_b[i])});
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_pending", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_sum", bus.rsp_sum, e.sum);
        end
      end
    end
  end

  task automatic pd();
    @(posedge clock);
    #1;
  endtask

  task automatic nk();
    @(negedge clock);
  endtask

  task automatic reset_dut();
    pd();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    pd();
    pd();
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (10) pd();
    nk();
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_rsp_idle"}, bus.rsp_valid, 0);
    pd();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] t2_exp [7];
    logic [3:0] acc;
    int         n, issued;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // reset values, with requests pending to show req_ready stays low
    #2 bus.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_add_valid", bus.add_valid, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    bus.req_valid = '0;
    pd();
    pd();
    reset_n = 1'b1;

    // 1: single request from requester 1, 1.0 + 2.0
    pd();
    bus.req_valid = 4'b0010;
    bus.req_a[1]  = 32'h3F800000;
    bus.req_b[1]  = 32'h40000000;
    bus.rsp_ready = 1'b1;
    nk(); chk("t1_ready", bus.req_ready, 4'b0010);
    pd(); bus.req_valid = '0;
    nk(); chk("t1_add_valid", bus.add_valid, 1); chk("t1_add_a", bus.add_a, 32'h3F800000);
          chk("t1_add_b", bus.add_b, 32'h40000000);
    pd(); nk(); chk("t1_early2", bus.rsp_valid, 0);
    pd(); nk(); chk("t1_early3", bus.rsp_valid, 0);
    pd(); nk(); chk("t1_rsp_valid", bus.rsp_valid, 1);
                chk("t1_rsp_id", bus.rsp_id, 1);
                chk("t1_rsp_sum", bus.rsp_sum, 32'h40400000);
    pd(); nk(); chk("t1_rsp_gone", bus.rsp_valid, 0);
    drain("t1");

    // 2: all four requesting; with depth 4 and latency 3 the credit window
    //    allows four issues then one bubble (pop frees credit a cycle late)
    reset_dut();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i] = 32'h3F800000 + (32'(i) << 23);
      bus.req_b[i] = 32'h3F800000;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0010};
    for (int t = 0; t < 7; t++) begin
      nk(); chk($sformatf("t2_grant%0d", t), bus.req_ready, t2_exp[t]);
      pd();
    end
    drain("t2");

    // 3: consumer stalled, requester 0 streams
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 32'h3F800000;
    bus.req_b[0]  = 32'h3F800000;
    n = 0;
    for (int t = 0; t < 10; t++) begin
      nk();
      chk($sformatf("t3_ready%0d", t), bus.req_ready, (t < D) ? 4'b0001 : 4'b0000);
      if (bus.req_ready[0]) n++;
      pd();
      if (n > 0) bus.req_a[0] = 32'h3F800000 + (32'(n) << 23);
    end
    chk("t3_accepts", n, D);
    bus.rsp_ready = 1'b1;
    nk(); chk("t3_pop_valid", bus.rsp_valid, 1); chk("t3_pop_cycle_ready", bus.req_ready, 0);
    pd(); bus.rsp_ready = 1'b0;
    nk(); chk("t3_after_pop_ready", bus.req_ready, 4'b0001);
    pd();
    nk(); chk("t3_one_more_only", bus.req_ready, 0);
    pd();
    drain("t3");

    // 4: fill the FIFO, then random consumer back-pressure with random requesters
    issued = 0;
    for (int cyc = 0; cyc < 300 && issued < 16; cyc++) begin
      bus.rsp_ready = (cyc >= 12) && ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++)
        if (!bus.req_valid[i] && (issued + $countones(bus.req_valid)) < 16 &&
            $urandom_range(0, 1) == 1) begin
          bus.req_valid[i] = 1'b1;
          bus.req_a[i]     = rnd_fp();
          bus.req_b[i]     = rnd_fp();
        end
      nk();
      acc = bus.req_valid & bus.req_ready;
      issued += $countones(acc);
      pd();
      bus.req_valid = bus.req_valid & ~acc;
    end
    chk("t4_issued", issued, 16);
    drain("t4");

    // 5: reset with two results buffered and two in flight
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 32'h40000000;
    bus.req_b[0]  = 32'h40000000;
    nk(); chk("t5_iss0", bus.req_ready, 4'b0001);
    pd(); nk(); chk("t5_iss1", bus.req_ready, 4'b0001);
    pd(); bus.req_valid = '0;
    nk(); pd(); nk();
    pd(); bus.req_valid = 4'b0001;
    nk(); chk("t5_iss4", bus.req_ready, 4'b0001);
    pd(); nk(); chk("t5_iss5", bus.req_ready, 4'b0001); chk("t5_buffered", bus.rsp_valid, 1);
    pd();
    bus.req_valid = '0;
    reset_n       = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rst_rsp_id", bus.rsp_id, 0);
    chk("t5_rst_rsp_sum", bus.rsp_sum, 0);
    chk("t5_rst_add_valid", bus.add_valid, 0);
    chk("t5_rst_add_a", bus.add_a, 0);
    chk("t5_rst_add_b", bus.add_b, 0);
    chk("t5_rst_req_ready", bus.req_ready, 0);
    pd(); pd();
    reset_n       = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_a[2]  = 32'h40400000;
    bus.req_b[2]  = 32'h3F800000;
    nk(); chk("t5_new_ready", bus.req_ready, 4'b0100);
    pd(); bus.req_valid = '0;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      nk();
      if (bus.rsp_valid) begin
        n++;
        chk("t5_rsp_id", bus.rsp_id, 2);
        chk("t5_rsp_sum", bus.rsp_sum, 32'h40800000);
      end
      pd();
    end
    chk("t5_rsp_count", n, 1);

    // 6: pointer wrap from requester 3 back to 0
    reset_dut();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    bus.req_a[3]  = 32'h3F800000;
    bus.req_b[3]  = 32'h40800000;
    bus.req_a[2]  = 32'h40000000;
    bus.req_b[2]  = 32'h40800000;
    nk(); chk("t6_only3", bus.req_ready, 4'b1000);
    pd(); bus.req_valid = 4'b1100;
    nk(); chk("t6_wrap_to2", bus.req_ready, 4'b0100);
    pd(); bus.req_valid = 4'b1000;
    nk(); chk("t6_then3", bus.req_ready, 4'b1000);
    pd();
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
